fifo_ctrl: RTL and testbench

//  - Pointer/flag controller that sequences the fifo_data storage array for the UART TX/RX FIFOs.
//  - Turns push/pop requests into wr_en, wr_addr and rd_addr, and keeps occupancy, full/empty and

---
 rtl/fifo_ctrl.sv | 156 +++++++++++++++
 tb/tb_fifo_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for the UART TX/RX FIFO storage array.
// First-word-fall-through: the head word sits at rd_addr whenever empty is low.
// Pointers carry one extra wrap bit; the storage address is the low AW bits.
// Status flags are registered from the next-state occupancy, so they reflect
// the result of an edge during the following cycle.
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// outputs and the err_clr input. Without it those ports and flops do not exist.
module fifo_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 2,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          push,
  input  logic          pop,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic          err_clr,
  output logic          overflow,
  output logic          underflow
`endif
);

  // Parameter legality is checked at elaboration.
  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_ctrl: FIFO_DEPTH must be a power of 2 and >= 4");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > FIFO_DEPTH)) begin : g_bad_af
    $error("fifo_ctrl: AF_LEVEL must lie in 1..FIFO_DEPTH");
  end
  if (AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("fifo_ctrl: AE_LEVEL must lie in 0..FIFO_DEPTH-1");
  end

  localparam logic [AW:0] CntOne   = (AW + 1)'(1);
  localparam logic [AW:0] CntDepth = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CntAf    = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] CntAe    = (AW + 1)'(AE_LEVEL);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        af_q, af_d;
  logic        ae_q, ae_d;
  logic        push_ok, pop_ok;

  // Request acceptance, write enable and next-state pointers/occupancy.
  always_comb begin
    pop_ok   = pop & ~empty_q;
    // A push into a full FIFO is accepted only when the head leaves in the same edge.
    push_ok  = push & (~full_q | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + CntOne;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + CntOne;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntDepth);
    empty_d = (count_d == '0);
    af_d    = (count_d >= CntAf);
    ae_d    = (count_d <= CntAe);
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  // Output mapping; wr_en is held low while reset is asserted so no write is in flight.
  always_comb begin
    wr_en        = push_ok & rstN;
    wr_addr      = wr_ptr_q[AW-1:0];
    rd_addr      = rd_ptr_q[AW-1:0];
    full         = full_q;
    empty        = empty_q;
    almost_full  = af_q;
    almost_empty = ae_q;
    count        = count_q;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; a same-cycle set wins over err_clr.
  always_comb begin
    overflow_d  = overflow_q & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    if (push & full_q & ~pop_ok) begin
      overflow_d = 1'b1;
    end
    if (pop & empty_q) begin
      underflow_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  // Internal consistency: occupancy always equals the pointer distance.
  a_count_ptr : assert property (@(posedge clk) disable iff (!rstN)
    count_q == (wr_ptr_q - rd_ptr_q));
  a_full_empty : assert property (@(posedge clk) disable iff (!rstN)
    !(full_q && empty_q));
  a_count_max : assert property (@(posedge clk) disable iff (!rstN)
    count_q <= CntDepth);

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: randomized bench for fifo_ctrl (depth 8, AF 6, AE 1).
// Reference model is a queue of the data words held plus running push/pop
// totals; a small array stands in for the storage block and is written from
// the DUT's wr_en/wr_addr so readback order checks the whole address path.
module tb_fifo_ctrl;

  localparam int unsigned Depth = 8;
  localparam int unsigned Af    = 6;
  localparam int unsigned Ae    = 1;
  localparam int unsigned Aw    = 3;

  logic          clk;
  logic          rstN;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic [Aw-1:0] wr_addr;
  logic [Aw-1:0] rd_addr;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [Aw:0]   count;
  logic          err_clr;
  logic          overflow;
  logic          underflow;

  fifo_ctrl #(
    .FIFO_DEPTH (Depth),
    .AF_LEVEL   (Af),
    .AE_LEVEL   (Ae)
  ) u_dut (
    .clk          (clk),
    .rstN         (rstN),
    .push         (push),
    .pop          (pop),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

`ifndef FIFO_ERR_FLAGS_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_fail   = 0;
  logic [7:0] mem [Depth];
  int        q [$];
  int        n_push;
  int        n_pop;
  bit        ovf_m;
  bit        udf_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    n_push = 0;
    n_pop  = 0;
    ovf_m  = 1'b0;
    udf_m  = 1'b0;
  endtask

  // Registered state compared against the model; called away from the rising edge.
  task automatic check_state(input string tag);
    int sz;
    sz = q.size();
    check({tag, ".count"}, 32'(count), 32'(sz));
    check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    check({tag, ".full"}, 32'(full), 32'(sz == Depth));
    check({tag, ".afull"}, 32'(almost_full), 32'(sz >= Af));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(sz <= Ae));
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(n_push % Depth));
    check({tag, ".rd_addr"}, 32'(rd_addr), 32'(n_pop % Depth));
    check({tag, ".not_full_and_empty"}, 32'(full & empty), 32'(0));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    check({tag, ".underflow"}, 32'(underflow), 32'(udf_m));
`endif
  endtask

  // One clock of stimulus; entered and left just after a falling edge.
  task automatic step(input logic p, input logic o, input logic clr, input string tag);
    int         sz;
    bit         pop_ok;
    bit         push_ok;
    logic [7:0] d;
    logic       we;
    logic [Aw-1:0] wa;
    sz      = q.size();
    pop_ok  = o && (sz > 0);
    push_ok = p && ((sz < Depth) || pop_ok);
    d       = 8'($urandom);
    push    = p;
    pop     = o;
    err_clr = clr;
    #1;
    check({tag, ".wr_en"}, 32'(wr_en), 32'(push_ok));
    if (sz > 0) begin
      check({tag, ".head"}, 32'(mem[rd_addr]), 32'(q[0]));
    end
    we = wr_en;
    wa = wr_addr;
    @(posedge clk);
    if (we) begin
      mem[wa] = d;
    end
    if (pop_ok) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (push_ok) begin
      q.push_back(int'(d));
      n_push++;
    end
    if (p && (sz == Depth) && !pop_ok) begin
      ovf_m = 1'b1;
    end else if (clr) begin
      ovf_m = 1'b0;
    end
    if (o && (sz == 0)) begin
      udf_m = 1'b1;
    end else if (clr) begin
      udf_m = 1'b0;
    end
    @(negedge clk);
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    check_state(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".count"}, 32'(count), 32'(0));
    check({tag, ".empty"}, 32'(empty), 32'(1));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(1));
    check({tag, ".full"}, 32'(full), 32'(0));
    check({tag, ".afull"}, 32'(almost_full), 32'(0));
    check({tag, ".wr_en"}, 32'(wr_en), 32'(0));
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(0));
    check({tag, ".rd_addr"}, 32'(rd_addr), 32'(0));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"}, 32'(overflow), 32'(0));
    check({tag, ".underflow"}, 32'(underflow), 32'(0));
`endif
  endtask

  // Reset pulse with a push request held, which must not produce a write.
  task automatic do_reset();
    push    = 1'b1;
    pop     = 1'b0;
    err_clr = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    push = 1'b0;
    rstN = 1'b1;
    model_clear();
    #1;
    check_state("post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bias;
    int pw;
    rstN    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_reset_outputs("init");
    rstN = 1'b1;
    @(negedge clk);

    // Fill to full.
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0, 1'b0, "fill");

    // Push while full without pop is dropped.
    step(1'b1, 1'b0, 1'b0, "push_full");
    step(1'b0, 1'b0, 1'b1, "err_clr");

    // Simultaneous push/pop while full keeps it full and wraps the write address.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "full_pp");

    // Drain, checking order.
    for (int i = 0; i < Depth; i++) step(1'b0, 1'b1, 1'b0, "drain");
    step(1'b0, 1'b1, 1'b0, "pop_empty");

    // Push+pop on empty from fresh reset: pop ignored, push lands.
    do_reset();
    step(1'b1, 1'b1, 1'b0, "empty_pp");
    check("empty_pp.count1", 32'(count), 32'(1));
    check("empty_pp.wr1", 32'(wr_addr), 32'(1));
    check("empty_pp.rd0", 32'(rd_addr), 32'(0));
    step(1'b0, 1'b1, 1'b0, "pop_last");
    step(1'b0, 1'b1, 1'b1, "pop_empty2");

    // Randomized traffic with alternating fill/drain bias, several wraps.
    for (int i = 0; i < 240; i++) begin
      bias = ((i / 30) % 2) == 0;
      pw   = bias ? 75 : 30;
      step($urandom_range(99) < pw, $urandom_range(99) >= pw - 10,
           $urandom_range(15) == 0, "rand");
    end

    // Asynchronous reset mid-cycle with five entries held.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "pre_arst");
    #2;
    push = 1'b1;
    rstN = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge clk);
    check_reset_outputs("arst_hold");
    push = 1'b0;
    rstN = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "after_arst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
